// File: rtl/textbuf_pkg.sv
// Shared definitions for the scrolling text buffer: host command encodings
// and the controller state enumeration.
package textbuf_pkg;

    typedef enum logic [1:0] {
        CMD_PUT     = 2'd0,
        CMD_NEWLINE = 2'd1,
        CMD_CLS     = 2'd2,
        CMD_HOME    = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_LINE = 2'd1,
        CLR_ALL  = 2'd2
    } state_e;

endpackage

// File: rtl/textbuf_ram.sv
// Simple dual-port character store: one write port, one registered read port
// with read-first behaviour, shaped for block-RAM inference.
module textbuf_ram #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: the array carries no reset so it maps onto block RAM; contents are
    // initialised by the controller's clear pass instead.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: non-blocking assignments here are what make a same-address read
    // return the pre-write contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/textbuf_scroll.sv
// Text-mode character buffer with hardware scrolling: a circular row offset
// turns a scroll into a single-row clear instead of a full memory move.
module textbuf_scroll
    import textbuf_pkg::*;
#(
    parameter int              COLS   = 64,
    parameter int              ROWS   = 64,
    parameter int              DATA_W = 8,
    parameter logic [DATA_W-1:0] BLANK = 8'h20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [1:0]               wr_cmd,
    input  logic [DATA_W-1:0]        wr_char,
    input  logic                     rd_en,
    input  logic [$clog2(COLS)-1:0]  rd_col,
    input  logic [$clog2(ROWS)-1:0]  rd_row,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(COLS)-1:0]  cur_x,
    output logic [$clog2(ROWS)-1:0]  cur_y,
    output logic                     busy
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int ADDR_W = COL_W + ROW_W;
    localparam int CELLS  = COLS * ROWS;

    state_e             r_state;
    state_e             w_next_state;
    logic [COL_W-1:0]   r_cur_x;
    logic [ROW_W-1:0]   r_cur_y;
    logic [ROW_W-1:0]   r_top_row;
    logic [ADDR_W-1:0]  r_clr_cnt;

    cmd_e               w_cmd;
    logic               w_accept;
    logic               w_x_last;
    logic               w_y_last;
    logic               w_line_end;
    logic               w_scroll;
    logic               w_clr_done;
    logic [ROW_W-1:0]   w_put_row;
    logic [ROW_W-1:0]   w_old_top;
    logic [ROW_W-1:0]   w_rd_row;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [DATA_W-1:0]  w_wdata;

    assign w_cmd      = cmd_e'(wr_cmd);
    assign w_accept   = wr_valid && (r_state == IDLE);
    assign w_x_last   = (r_cur_x == COL_W'(COLS - 1));
    assign w_y_last   = (r_cur_y == ROW_W'(ROWS - 1));
    assign w_line_end = (w_cmd == CMD_NEWLINE) || ((w_cmd == CMD_PUT) && w_x_last);
    assign w_scroll   = w_accept && w_line_end && w_y_last;

    // Physical rows wrap naturally at ROW_W bits.
    assign w_put_row  = r_cur_y + r_top_row;
    assign w_rd_row   = rd_row + r_top_row;
    // After a scroll the vacated physical row is the one just below the new top.
    assign w_old_top  = r_top_row - ROW_W'(1);

    always_comb begin
        w_clr_done = 1'b0;
        if (r_state == CLR_LINE) begin
            w_clr_done = (r_clr_cnt == ADDR_W'(COLS - 1));
        end else if (r_state == CLR_ALL) begin
            w_clr_done = (r_clr_cnt == ADDR_W'(CELLS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLR_ALL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_scroll) begin
                    w_next_state = CLR_LINE;
                end else if (w_accept && (w_cmd == CMD_CLS)) begin
                    w_next_state = CLR_ALL;
                end
            end
            CLR_LINE, CLR_ALL: begin
                if (w_clr_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    always_comb begin
        wr_ready = 1'b0;
        busy     = 1'b0;
        w_we     = 1'b0;
        w_waddr  = r_clr_cnt;
        w_wdata  = BLANK;
        case (r_state)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid && (w_cmd == CMD_PUT)) begin
                    w_we    = 1'b1;
                    w_waddr = {w_put_row, r_cur_x};
                    w_wdata = wr_char;
                end
            end
            CLR_LINE: begin
                busy    = 1'b1;
                w_we    = 1'b1;
                w_waddr = {w_old_top, r_clr_cnt[COL_W-1:0]};
            end
            CLR_ALL: begin
                busy    = 1'b1;
                w_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_x   <= '0;
            r_cur_y   <= '0;
            r_top_row <= '0;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (w_cmd)
                            CMD_PUT, CMD_NEWLINE: begin
                                if (w_line_end) begin
                                    r_cur_x <= '0;
                                    if (!w_y_last) begin
                                        r_cur_y <= r_cur_y + ROW_W'(1);
                                    end else begin
                                        r_top_row <= r_top_row + ROW_W'(1);
                                    end
                                end else begin
                                    r_cur_x <= r_cur_x + COL_W'(1);
                                end
                            end
                            CMD_CLS: begin
                                r_cur_x   <= '0;
                                r_cur_y   <= '0;
                                r_top_row <= '0;
                            end
                            CMD_HOME: begin
                                r_cur_x <= '0;
                                r_cur_y <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                CLR_LINE, CLR_ALL: begin
                    r_clr_cnt <= w_clr_done ? '0 : r_clr_cnt + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    textbuf_ram #(
        .DEPTH (CELLS),
        .WIDTH (DATA_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (rd_en),
        .i_raddr ({w_rd_row, rd_col}),
        .o_rdata (rd_data)
    );

    assign cur_x = r_cur_x;
    assign cur_y = r_cur_y;

endmodule

// File: tb/tb_textbuf_scroll.sv
// Randomised scoreboard bench for textbuf_scroll: a display-relative screen
// model (rows physically shifted on scroll) predicts every read.
module tb_textbuf_scroll;

    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int DW    = 8;
    localparam int CELLS = COLS * ROWS;
    localparam logic [DW-1:0] BLANK = 8'h20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [1:0]    wr_cmd = 2'd0;
    logic [DW-1:0] wr_char = '0;
    logic          rd_en = 1'b0;
    logic [2:0]    rd_col = '0;
    logic [1:0]    rd_row = '0;
    logic [DW-1:0] rd_data;
    logic [2:0]    cur_x;
    logic [1:0]    cur_y;
    logic          busy;

    always #5 clk = ~clk;

    textbuf_scroll #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .DATA_W (DW),
        .BLANK  (BLANK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_cmd   (wr_cmd),
        .wr_char  (wr_char),
        .rd_en    (rd_en),
        .rd_col   (rd_col),
        .rd_row   (rd_row),
        .rd_data  (rd_data),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;

    // Screen as the viewer sees it; row 0 is the top display row.
    logic [DW-1:0] screen [ROWS][COLS];
    int            m_x;
    int            m_y;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cls();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                screen[r][c] = BLANK;
        m_x = 0;
        m_y = 0;
    endtask

    task automatic model_newline(output bit scrolled);
        scrolled = 1'b0;
        m_x = 0;
        if (m_y < ROWS - 1) begin
            m_y++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    screen[r][c] = screen[r+1][c];
            for (int c = 0; c < COLS; c++)
                screen[ROWS-1][c] = BLANK;
            scrolled = 1'b1;
        end
    endtask

    task automatic model_cmd(input logic [1:0] cmd, input logic [DW-1:0] ch, output bit scrolled);
        scrolled = 1'b0;
        case (cmd)
            2'd0: begin
                screen[m_y][m_x] = ch;
                if (m_x < COLS - 1) m_x++;
                else model_newline(scrolled);
            end
            2'd1: model_newline(scrolled);
            2'd2: model_cls();
            default: begin
                m_x = 0;
                m_y = 0;
            end
        endcase
    endtask

    task automatic set_read(input int row, input int col);
        rd_en  = 1'b1;
        rd_row = 2'(row);
        rd_col = 3'(col);
        exp_q.push_back(screen[row][col]);
    endtask

    task automatic read_cell(input int row, input int col);
        set_read(row, col);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic read_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                read_cell(r, c);
    endtask

    // mode 1: reads of rows untouched by a line clear; mode 2: reads of cells
    // a full clear has already blanked (top row is 0, so display = physical).
    task automatic wait_busy(input int exp_n, input int mode);
        int n = 0;
        int a;
        while (busy === 1'b1 && n < 2 * CELLS + 8) begin
            check("ready_while_busy", {31'd0, wr_ready}, 32'd0);
            if (mode == 1) begin
                set_read($urandom_range(ROWS - 2, 0), $urandom_range(COLS - 1, 0));
            end else if (mode == 2 && n >= 1) begin
                a = $urandom_range(n - 1, 0);
                set_read(a / COLS, a % COLS);
            end
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            n++;
        end
        check("busy_cycles", n, exp_n);
    endtask

    task automatic send(input logic [1:0] cmd, input logic [DW-1:0] ch,
                        input bit with_rd, input int row, input int col);
        int n = 0;
        bit sc;
        while (wr_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_before_cmd", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1;
        wr_cmd   = cmd;
        wr_char  = ch;
        if (with_rd) set_read(row, col);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        model_cmd(cmd, ch, sc);
        if (cmd == 2'd2) wait_busy(CELLS, 2);
        else if (sc) wait_busy(COLS, 1);
        else check("busy_after_cmd", {31'd0, busy}, 32'd0);
        check("cur_x", cur_x, m_x);
        check("cur_y", cur_y, m_y);
    endtask

    function automatic logic [DW-1:0] rand_char();
        return DW'($urandom_range(8'h7e, 8'h21));
    endfunction

    // Monitor: pops one expectation per completed read, otherwise checks hold.
    initial begin
        logic          rst_q;
        logic          rd_q;
        logic [DW-1:0] hold;
        logic [DW-1:0] e;
        hold = '0;
        forever begin
            @(posedge clk);
            rst_q = reset;
            rd_q  = rd_en;
            @(negedge clk);
            if (rst_q) begin
                check("rd_data_reset", rd_data, 0);
                hold = '0;
            end else if (rd_q) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: read completed with no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                    hold = e;
                end
            end else begin
                check("rd_hold", rd_data, hold);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_cls();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_ready", {31'd0, wr_ready}, 32'd0);
        check("reset_cur_x", cur_x, 0);
        check("reset_cur_y", cur_y, 0);
        wait_busy(CELLS, 0);
        read_all();

        // PUT 'A' at home together with a read of the same cell.
        send(2'd0, 8'h41, 1'b1, 0, 0);
        read_cell(0, 0);
        check("put_a_cur_x", cur_x, 1);

        repeat (8) send(2'd0, rand_char(), 1'b0, 0, 0);
        check("nine_puts_cur_x", cur_x, 1);
        check("nine_puts_cur_y", cur_y, 1);
        for (int c = 0; c < COLS; c++) begin
            read_cell(0, c);
            read_cell(1, c);
        end

        while (!(m_y == ROWS - 1 && m_x == COLS - 1))
            send(2'd0, rand_char(), $urandom_range(1, 0), $urandom_range(ROWS - 1, 0),
                 $urandom_range(COLS - 1, 0));
        send(2'd0, rand_char(), 1'b0, 0, 0);
        for (int c = 0; c < COLS; c++) read_cell(0, c);
        send(2'd1, 8'h00, 1'b0, 0, 0);
        check("scroll_cur_y", cur_y, ROWS - 1);
        read_all();

        for (int i = 0; i < 120; i++) begin
            int r;
            logic [1:0] cmd;
            r   = $urandom_range(99, 0);
            cmd = (r < 72) ? 2'd0 : (r < 88) ? 2'd1 : (r < 96) ? 2'd3 : 2'd2;
            send(cmd, rand_char(), $urandom_range(1, 0), $urandom_range(ROWS - 1, 0),
                 $urandom_range(COLS - 1, 0));
            if (i % 30 == 29) read_all();
        end

        // Guarantee at least one scroll, then clear the whole screen.
        repeat (ROWS) send(2'd1, 8'h00, 1'b0, 0, 0);
        send(2'd2, 8'h00, 1'b0, 0, 0);
        check("cls_cur_x", cur_x, 0);
        check("cls_cur_y", cur_y, 0);
        read_all();
        send(2'd0, 8'h5a, 1'b1, 0, 0);
        read_cell(0, 0);

        // Reset in the middle of a full clear restarts it from the beginning.
        send(2'd0, rand_char(), 1'b0, 0, 0);
        wr_valid = 1'b1;
        wr_cmd   = 2'd2;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_cls();
        check("midreset_busy", {31'd0, busy}, 32'd1);
        wait_busy(CELLS, 0);
        check("midreset_cur_x", cur_x, 0);
        check("midreset_cur_y", cur_y, 0);
        read_all();

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
